wb_burst_master: RTL and testbench

//  Synthesizable Wishbone B3 master that turns a command (address, beat count, direction,

---
 rtl/wb_burst_master.sv | 176 +++++++++++++++++
 tb/tb_wb_burst_master.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// Wishbone B3 master: turns one command (address, beat count, direction, classic or
// linear burst) plus a write-data stream into bus cycles and returns read beats.
module wb_burst_master #(
  parameter int dw = 32,
  parameter int aw = 32,
  parameter int LW = 8
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [aw-1:0]   cmd_adr,
  input  logic [LW-1:0]   cmd_len,
  input  logic            cmd_burst,
  input  logic            wdat_valid,
  output logic            wdat_ready,
  input  logic [dw-1:0]   wdat,
  input  logic [dw/8-1:0] wdat_sel,
  output logic            rdat_valid,
  output logic [dw-1:0]   rdat,
  output logic            done_valid,
  output logic            done_err,
  output logic [aw-1:0]   wb_adr_o,
  output logic [dw-1:0]   wb_dat_o,
  output logic [dw/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [dw-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam logic [aw-1:0] STEP = aw'(dw/8);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP, S_DONE} state_t;

  state_t        r_state;
  logic          r_burst;
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_cnt;

  logic          w_last;
  logic          w_ack;
  logic          w_term;
  logic          w_wdat_hs;
  logic [LW-1:0] w_cnt_nxt;
  logic [2:0]    w_cti_nxt;
  logic [aw-1:0] w_adr_nxt;

  assign w_last    = (r_cnt == r_len);
  assign w_term    = wb_cyc_o & wb_stb_o & (wb_err_i | wb_rty_i);
  assign w_ack     = wb_cyc_o & wb_stb_o & wb_ack_i & ~wb_err_i & ~wb_rty_i;
  assign w_cnt_nxt = r_cnt + LW'(1);
  assign w_adr_nxt = wb_adr_o + STEP;
  assign w_cti_nxt = !r_burst ? 3'b000 : ((w_cnt_nxt == r_len) ? 3'b111 : 3'b010);

  // Write data is taken while the strobe is idle, or in the ack cycle of a burst
  // beat so the next beat can follow without a bubble.
  assign wdat_ready = (r_state == S_ACTIVE) & wb_we_o &
                      (~wb_stb_o | (r_burst & w_ack & ~w_last));
  assign w_wdat_hs  = wdat_valid & wdat_ready;

  // Command sequencing and all registered bus/user outputs.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state    <= S_IDLE;
      r_burst    <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      cmd_ready  <= 1'b0;
      rdat_valid <= 1'b0;
      rdat       <= '0;
      done_valid <= 1'b0;
      done_err   <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_cti_o   <= 3'b000;
      wb_bte_o   <= 2'b00;
    end else begin
      rdat_valid <= 1'b0;
      done_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            r_len     <= cmd_len;
            r_burst   <= cmd_burst;
            r_cnt     <= '0;
            wb_we_o   <= cmd_we;
            wb_adr_o  <= cmd_adr;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= ~cmd_we;
            wb_bte_o  <= 2'b00;
            wb_cti_o  <= !cmd_burst ? 3'b000 :
                         ((cmd_len == '0) ? 3'b111 : 3'b010);
            if (!cmd_we) begin
              wb_sel_o <= '1;
            end
            r_state   <= S_ACTIVE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_ACTIVE: begin
          // err/rty win over a simultaneous ack; the command is abandoned.
          if (w_term) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_cti_o   <= 3'b000;
            wb_we_o    <= 1'b0;
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            r_state    <= S_DONE;
          end else if (w_ack) begin
            wb_adr_o <= w_adr_nxt;
            r_cnt    <= w_cnt_nxt;
            if (!wb_we_o) begin
              rdat       <= wb_dat_i;
              rdat_valid <= 1'b1;
            end
            if (w_last) begin
              wb_cyc_o   <= 1'b0;
              wb_stb_o   <= 1'b0;
              wb_cti_o   <= 3'b000;
              wb_we_o    <= 1'b0;
              done_valid <= 1'b1;
              done_err   <= 1'b0;
              r_state    <= S_DONE;
            end else begin
              wb_cti_o <= w_cti_nxt;
              if (!r_burst) begin
                wb_stb_o <= 1'b0;
                r_state  <= S_GAP;
              end else if (!wb_we_o) begin
                wb_stb_o <= 1'b1;
              end else if (w_wdat_hs) begin
                wb_dat_o <= wdat;
                wb_sel_o <= wdat_sel;
                wb_stb_o <= 1'b1;
              end else begin
                wb_stb_o <= 1'b0;
              end
            end
          end else if (!wb_stb_o && w_wdat_hs) begin
            wb_dat_o <= wdat;
            wb_sel_o <= wdat_sel;
            wb_stb_o <= 1'b1;
          end else begin
            r_state <= S_ACTIVE;
          end
        end
        S_GAP: begin
          wb_stb_o <= ~wb_we_o;
          r_state  <= S_ACTIVE;
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: behavioural slave with wait/err injection,
// write-data feeder, and queue scoreboard for bus beats, read data and completions.
module tb_wb_burst_master;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_burst;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat;
  logic [3:0]  wdat_sel;
  logic        rdat_valid, done_valid, done_err;
  logic [31:0] rdat;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  wb_burst_master #(.dw(32), .aw(32), .LW(8)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat), .wdat_sel(wdat_sel),
    .rdat_valid(rdat_valid), .rdat(rdat), .done_valid(done_valid), .done_err(done_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [31:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  beat_t       exp_beats[$];
  logic [31:0] exp_rdat[$];
  logic        exp_done[$];

  int errors = 0;
  int checks = 0;

  int s_wait = 0, s_wcnt = 0, s_beat = 0, s_err_at = -1;
  logic [31:0] fd_dat[$];
  logic [3:0]  fd_sel[$];
  int fd_idx = 0, fd_stall_at = -1, fd_stall = 0;
  logic fd_hs = 1'b0;

  logic        tr_stb[$], tr_cyc[$];
  logic [31:0] tr_adr[$];
  logic [2:0]  tr_cti[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]};
  endfunction

  // Slave responder, beat scoreboard and write-data feeder, all on the falling edge.
  always @(negedge wb_clk) begin
    beat_t b;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    if (wb_rst_n && wb_cyc_o && wb_stb_o) begin
      if (s_wcnt >= s_wait) begin
        s_wcnt = 0;
        wb_ack_i = 1'b1;
        wb_err_i = (s_beat == s_err_at);
        wb_dat_i = rd_of(wb_adr_o);
        s_beat++;
        if (exp_beats.size() == 0) begin
          chk("beat_extra", 64'd1, 64'd0);
        end else begin
          b = exp_beats.pop_front();
          chk("beat_adr", 64'(wb_adr_o), 64'(b.adr));
          chk("beat_cti", 64'(wb_cti_o), 64'(b.cti));
          chk("beat_we", 64'(wb_we_o), 64'(b.we));
          chk("beat_bte", 64'(wb_bte_o), 64'd0);
          chk("beat_sel", 64'(wb_sel_o), 64'(b.sel));
          if (b.we) chk("beat_dat", 64'(wb_dat_o), 64'(b.dat));
        end
      end else begin
        s_wcnt++;
      end
    end else begin
      s_wcnt = 0;
    end
    if (fd_hs) begin
      fd_idx++;
      fd_hs = 1'b0;
    end
    if (fd_idx < fd_dat.size()) begin
      if (fd_idx == fd_stall_at && fd_stall > 0) begin
        wdat_valid = 1'b0;
        fd_stall--;
      end else begin
        wdat_valid = 1'b1;
        wdat = fd_dat[fd_idx];
        wdat_sel = fd_sel[fd_idx];
      end
    end else begin
      wdat_valid = 1'b0;
    end
    #1;
    fd_hs = wdat_valid && wdat_ready;
  end

  // Read-data and completion scoreboard.
  always @(negedge wb_clk) begin
    if (rdat_valid) begin
      if (exp_rdat.size() == 0) chk("rdat_extra", 64'd1, 64'd0);
      else chk("rdat", 64'(rdat), 64'(exp_rdat.pop_front()));
    end
    if (done_valid) begin
      if (exp_done.size() == 0) chk("done_extra", 64'd1, 64'd0);
      else chk("done_err", 64'(done_err), 64'(exp_done.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_exp(input logic we, input logic [31:0] adr, input int len,
                          input logic burst, input int nb, input int err_at);
    beat_t b;
    for (int k = 0; k < nb; k++) begin
      b.adr = adr + 32'(4 * k);
      b.cti = !burst ? 3'b000 : ((k == len) ? 3'b111 : 3'b010);
      b.we  = we;
      b.dat = we ? fd_dat[k] : 32'h0;
      b.sel = we ? fd_sel[k] : 4'hF;
      exp_beats.push_back(b);
      if (!we && k != err_at) exp_rdat.push_back(rd_of(b.adr));
    end
    exp_done.push_back(err_at >= 0);
  endtask

  task automatic issue(input logic we, input logic [31:0] adr, input logic [7:0] len,
                       input logic burst);
    int n = 0;
    s_beat = 0;
    cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_burst = burst; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge wb_clk);
      n++;
    end
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge wb_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic trace(input string tag);
    int n = 0;
    tr_stb.delete(); tr_cyc.delete(); tr_adr.delete(); tr_cti.delete();
    while (!done_valid && n < 60) begin
      tr_stb.push_back(wb_stb_o);
      tr_cyc.push_back(wb_cyc_o);
      tr_adr.push_back(wb_adr_o);
      tr_cti.push_back(wb_cti_o);
      @(negedge wb_clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_valid), 64'd1);
    chk({tag, "_cyc_low_at_done"}, 64'(wb_cyc_o), 64'd0);
    @(negedge wb_clk);
    chk({tag, "_queues_empty"},
        64'(exp_beats.size() + exp_rdat.size() + exp_done.size()), 64'd0);
  endtask

  task automatic tr_counts(output int ones, output int gaps, output int cyc_lo, output int run);
    int cur = 0;
    ones = 0; gaps = 0; cyc_lo = 0; run = 0;
    for (int i = 0; i < tr_stb.size(); i++) begin
      if (tr_stb[i]) begin ones++; cur++; if (cur > run) run = cur; end
      else cur = 0;
      if (tr_cyc[i] && !tr_stb[i]) gaps++;
      if (!tr_cyc[i]) cyc_lo++;
    end
  endtask

  initial begin
    int ones, gaps, cyc_lo, run, cnt;
    wb_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0; cmd_len = 8'h0; cmd_burst = 1'b0;
    wdat_valid = 1'b0; wdat = 32'h0; wdat_sel = 4'h0;
    wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;

    repeat (3) @(negedge wb_clk);
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_wdat_ready", 64'(wdat_ready), 64'd0);
    chk("rst_outs", 64'({rdat_valid, done_valid, wb_we_o, wb_cti_o, wb_adr_o}), 64'd0);
    #2 wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("rst_release_ready", 64'(cmd_ready), 64'd1);

    // 1: classic single read, two wait states
    s_wait = 2;
    push_exp(1'b0, 32'h100, 0, 1'b0, 1, -1);
    issue(1'b0, 32'h100, 8'd0, 1'b0);
    trace("t1");
    tr_counts(ones, gaps, cyc_lo, run);
    chk("t1_stb_cycles", 64'(ones), 64'd3);
    chk("t1_cyc_held", 64'(cyc_lo), 64'd0);
    cnt = 0;
    foreach (tr_cti[i]) if (tr_cti[i] != 3'b000) cnt++;
    chk("t1_cti_classic", 64'(cnt), 64'd0);

    // 2: linear write burst, data always ready, zero-wait slave
    s_wait = 0;
    fd_dat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    fd_sel = '{4'hF, 4'h3, 4'hC, 4'hF};
    fd_idx = 0; fd_stall_at = -1; fd_stall = 0;
    @(negedge wb_clk);
    push_exp(1'b1, 32'h1000, 3, 1'b1, 4, -1);
    issue(1'b1, 32'h1000, 8'd3, 1'b1);
    trace("t2");
    tr_counts(ones, gaps, cyc_lo, run);
    chk("t2_stb_run", 64'(run), 64'd4);
    chk("t2_stb_total", 64'(ones), 64'd4);
    chk("t2_cyc_held", 64'(cyc_lo), 64'd0);

    // 3: same burst with write data withheld for three cycles before beat 2
    fd_dat = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    fd_sel = '{4'hF, 4'hF, 4'h1, 4'h8};
    fd_idx = 0; fd_stall_at = 2; fd_stall = 3;
    @(negedge wb_clk);
    push_exp(1'b1, 32'h1000, 3, 1'b1, 4, -1);
    issue(1'b1, 32'h1000, 8'd3, 1'b1);
    trace("t3");
    tr_counts(ones, gaps, cyc_lo, run);
    cnt = 0;
    foreach (tr_stb[i]) if (tr_cyc[i] && !tr_stb[i] && tr_adr[i] == 32'h1008) cnt++;
    chk("t3_wait_at_1008", 64'(cnt), 64'd3);
    chk("t3_stb_total", 64'(ones), 64'd4);
    chk("t3_cyc_held", 64'(cyc_lo), 64'd0);
    fd_dat.delete(); fd_sel.delete(); fd_idx = 0; fd_stall_at = -1;

    // 4: classic read of three beats
    push_exp(1'b0, 32'h200, 2, 1'b0, 3, -1);
    issue(1'b0, 32'h200, 8'd2, 1'b0);
    trace("t4");
    tr_counts(ones, gaps, cyc_lo, run);
    chk("t4_stb_total", 64'(ones), 64'd3);
    chk("t4_gaps", 64'(gaps), 64'd2);
    chk("t4_len", 64'(tr_stb.size()), 64'd5);
    chk("t4_cyc_held", 64'(cyc_lo), 64'd0);

    // 5: read burst terminated by err (with ack) on beat 3, then a normal command
    s_err_at = 3;
    push_exp(1'b0, 32'h400, 7, 1'b1, 4, 3);
    issue(1'b0, 32'h400, 8'd7, 1'b1);
    trace("t5");
    chk("t5_trace_len", 64'(tr_stb.size()), 64'd4);
    s_err_at = -1;
    push_exp(1'b0, 32'h2000, 1, 1'b1, 2, -1);
    issue(1'b0, 32'h2000, 8'd1, 1'b1);
    trace("t5b");

    // 6: reset mid-burst, then a burst that wraps the address space
    s_wait = 1;
    push_exp(1'b0, 32'h3000, 7, 1'b1, 8, -1);
    issue(1'b0, 32'h3000, 8'd7, 1'b1);
    repeat (3) @(negedge wb_clk);
    #2 wb_rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("t6_rst_stb", 64'(wb_stb_o), 64'd0);
    chk("t6_rst_outs", 64'({cmd_ready, rdat_valid, done_valid, wb_cti_o, wb_adr_o}), 64'd0);
    exp_beats.delete(); exp_rdat.delete(); exp_done.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge wb_clk);
      chk("t6_no_done", 64'(done_valid), 64'd0);
    end
    #2 wb_rst_n = 1'b1;
    #1 chk("t6_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(negedge wb_clk);
    chk("t6_ready_after_edge", 64'(cmd_ready), 64'd1);
    s_wait = 0;
    push_exp(1'b0, 32'hFFFF_FFFC, 1, 1'b1, 2, -1);
    issue(1'b0, 32'hFFFF_FFFC, 8'd1, 1'b1);
    trace("t6");
    chk("t6_wrap_adr0", 64'(tr_adr[0]), 64'hFFFF_FFFC);
    chk("t6_wrap_adr1", 64'(tr_adr[1]), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
